booth_mul_sched: RTL

Sequential radix-2 Booth multiplier shared between two requesters, with a round-robin arbiter and start/done handshake. It replaces a per-requester combinational Booth array with one iterative datapath that retires one Booth step per clock. The block sits between two operand producers and the downstream result consumers. It owns arbitration, operand capture, iteration sequencing and result delivery.

---
 rtl/booth_mul_sched_if.sv | 29 ++
 rtl/booth_mul_sched.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/booth_mul_sched_if.sv
// Request/grant/result bundle between the two operand producers, the result
// consumers and the shared Booth multiplier. The multiplier uses the slave
// view; whoever drives requests and collects results uses the master view.
interface booth_mul_sched_if #(
  parameter int W = 5
);
  logic           req0;
  logic [W-1:0]   m0;
  logic [W-1:0]   q0;
  logic           req1;
  logic [W-1:0]   m1;
  logic [W-1:0]   q1;
  logic           gnt0;
  logic           gnt1;
  logic           done0;
  logic           done1;
  logic [2*W-1:0] product;
  logic           busy;

  modport master (
    output req0, m0, q0, req1, m1, q1,
    input  gnt0, gnt1, done0, done1, product, busy
  );

  modport slave (
    input  req0, m0, q0, req1, m1, q1,
    output gnt0, gnt1, done0, done1, product, busy
  );
endinterface

// File: rtl/booth_mul_sched.sv
// Shared sequential radix-2 Booth multiplier with a two-way round-robin
// arbiter. One Booth step retires per clock; a multiply takes W RUN cycles
// followed by one DONE cycle carrying the done pulse for the owner.
module booth_mul_sched #(
  parameter int W = 5
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  booth_mul_sched_if.slave       bus
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   m_q, m_d;          // captured multiplicand
  logic [W-1:0]   qr_q, qr_d;        // multiplier, shifted right each step
  logic [W:0]     a_q, a_d;          // accumulator, one guard bit for -2^(W-1)
  logic           qprev_q, qprev_d;  // bit shifted out of Q on the last step
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           owner_q, owner_d;  // requester that owns the running multiply
  logic           rr_q, rr_d;        // 1: requester 1 wins the next tie
  logic [2*W-1:0] product_q, product_d;
  logic           done0_q, done0_d;
  logic           done1_q, done1_d;
  logic           busy_q, busy_d;

  logic           sel1_s;
  logic           grant_s;
  logic [W:0]     m_ext_s;
  logic [W:0]     a_sum_s;
  logic [W:0]     a_shr_s;
  logic [W-1:0]   q_shr_s;
  logic           last_step_s;

  // Arbiter: pick the winner among pending requests; grant only in IDLE.
  always_comb begin
    sel1_s  = 1'b0;
    grant_s = 1'b0;
    if (bus.req0 && bus.req1) begin
      sel1_s = rr_q;
    end else if (bus.req1) begin
      sel1_s = 1'b1;
    end else begin
      sel1_s = 1'b0;
    end
    grant_s = rst_n_i & (state_q == IDLE) & (bus.req0 | bus.req1);
  end

  assign bus.gnt0 = grant_s & ~sel1_s;
  assign bus.gnt1 = grant_s & sel1_s;

  // One Booth step on {A, Q, q_prev}: add/subtract M, then arithmetic shift.
  always_comb begin
    m_ext_s = {m_q[W-1], m_q};
    case ({qr_q[0], qprev_q})
      2'b10:   a_sum_s = a_q - m_ext_s;
      2'b01:   a_sum_s = a_q + m_ext_s;
      default: a_sum_s = a_q;
    endcase
    a_shr_s     = {a_sum_s[W], a_sum_s[W:1]};
    q_shr_s     = {a_sum_s[0], qr_q[W-1:1]};
    last_step_s = (cnt_q == CW'(W - 1));
  end

  // Sequencer next state: capture on grant, iterate W steps, pulse done.
  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    qr_d      = qr_q;
    a_d       = a_q;
    qprev_d   = qprev_q;
    cnt_d     = cnt_q;
    owner_d   = owner_q;
    rr_d      = rr_q;
    product_d = product_q;
    done0_d   = 1'b0;
    done1_d   = 1'b0;
    busy_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_s) begin
          m_d     = sel1_s ? bus.m1 : bus.m0;
          qr_d    = sel1_s ? bus.q1 : bus.q0;
          a_d     = {(W + 1){1'b0}};
          qprev_d = 1'b0;
          cnt_d   = {CW{1'b0}};
          owner_d = sel1_s;
          rr_d    = ~sel1_s;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d     = a_shr_s;
        qr_d    = q_shr_s;
        qprev_d = qr_q[0];
        cnt_d   = cnt_q + CW'(1);
        if (last_step_s) begin
          product_d = {a_shr_s[W-1:0], q_shr_s};
          done0_d   = ~owner_q;
          done1_d   = owner_q;
          state_d   = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      m_q       <= {W{1'b0}};
      qr_q      <= {W{1'b0}};
      a_q       <= {(W + 1){1'b0}};
      qprev_q   <= 1'b0;
      cnt_q     <= {CW{1'b0}};
      owner_q   <= 1'b0;
      rr_q      <= 1'b0;
      product_q <= {(2 * W){1'b0}};
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      qr_q      <= qr_d;
      a_q       <= a_d;
      qprev_q   <= qprev_d;
      cnt_q     <= cnt_d;
      owner_q   <= owner_d;
      rr_q      <= rr_d;
      product_q <= product_d;
      done0_q   <= done0_d;
      done1_q   <= done1_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.done0   = done0_q;
  assign bus.done1   = done1_q;
  assign bus.product = product_q;
  assign bus.busy    = busy_q;

endmodule
